cp0_int_ctrl: RTL and testbench

Coprocessor-0 interrupt receiver for the MIPS CPU. It collects the six hardware interrupt request lines from bus devices, such as the timer's interrupt output, and gates them with the software mask and enable bits. It raises a held interrupt request to the pipeline, captures EPC on acknowledge, and returns from the handler on `eret`. It also serves `mfc0`/`mtc0` accesses to SR, Cause, EPC and PRId.

---
 rtl/cp0_int_ctrl_if.sv | 24 ++
 rtl/cp0_int_ctrl.sv | 126 ++++++++++++
 tb/tb_cp0_int_ctrl.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cp0_int_ctrl_if.sv
// CP0 access and interrupt-handshake bundle between the pipeline (master)
// and the coprocessor-0 interrupt receiver (slave).
interface cp0_int_ctrl_if;
  logic [4:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [31:0] pc;
  logic        bd;
  logic        int_ack;
  logic        eret;
  logic        int_req;
  logic [31:0] epc;

  modport master (
    output addr, we, wdata, pc, bd, int_ack, eret,
    input  rdata, int_req, epc
  );

  modport slave (
    input  addr, we, wdata, pc, bd, int_ack, eret,
    output rdata, int_req, epc
  );
endinterface

// File: rtl/cp0_int_ctrl.sv
// Coprocessor-0 interrupt receiver: SR/Cause/EPC/PRId, masked interrupt request,
// EPC capture on acknowledge and eret return. Define CP0_HWINT_SYNC_EN to add a
// 2-flop synchroniser on hw_int.
module cp0_int_ctrl #(
  parameter logic [31:0] PRID = 32'h0000_4D50
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [5:0]     hw_int,
  cp0_int_ctrl_if.slave  bus
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  // The state register is SR.EXL itself.
  typedef enum logic {
    RUN     = 1'b0,
    HANDLER = 1'b1
  } state_t;

  state_t      state_reg, state_next;
  logic [5:0]  im_reg, im_next;
  logic        ie_reg, ie_next;
  logic        bd_reg, bd_next;
  logic [31:0] epc_reg, epc_next;
  logic [5:0]  ip_reg;
  logic [5:0]  ip_src;

  logic        sr_wr;
  logic        epc_wr;
  logic        int_req_w;
  logic        take_int;

`ifdef CP0_HWINT_SYNC_EN
  logic [5:0] sync1_reg, sync2_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= hw_int;
      sync2_reg <= sync1_reg;
    end
  end

  assign ip_src = sync2_reg;
`else
  assign ip_src = hw_int;
`endif

  assign sr_wr     = bus.we && (bus.addr == ADDR_SR);
  assign epc_wr    = bus.we && (bus.addr == ADDR_EPC);
  assign int_req_w = (|(ip_reg & im_reg)) && ie_reg && (state_reg == RUN);
  assign take_int  = bus.int_ack && int_req_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= RUN;
      im_reg    <= '0;
      ie_reg    <= 1'b0;
      bd_reg    <= 1'b0;
      epc_reg   <= '0;
      ip_reg    <= '0;
    end else begin
      state_reg <= state_next;
      im_reg    <= im_next;
      ie_reg    <= ie_next;
      bd_reg    <= bd_next;
      epc_reg   <= epc_next;
      ip_reg    <= ip_src;
    end
  end

  // mtc0 is applied first; an accepted interrupt or an eret then overrides EXL/EPC.
  always_comb begin
    state_next = state_reg;
    im_next    = im_reg;
    ie_next    = ie_reg;
    bd_next    = bd_reg;
    epc_next   = epc_reg;

    if (sr_wr) begin
      im_next    = bus.wdata[15:10];
      ie_next    = bus.wdata[0];
      state_next = state_t'(bus.wdata[1]);
    end
    if (epc_wr) begin
      epc_next = {bus.wdata[31:2], 2'b00};
    end

    case (state_reg)
      RUN: begin
        if (take_int) begin
          state_next = HANDLER;
          bd_next    = bus.bd;
          epc_next   = bus.bd ? (bus.pc - 32'd4) : bus.pc;
        end
      end
      HANDLER: begin
        if (bus.eret) begin
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    bus.rdata = '0;
    case (bus.addr)
      ADDR_SR:    bus.rdata = {16'h0000, im_reg, 8'h00, (state_reg == HANDLER), ie_reg};
      ADDR_CAUSE: bus.rdata = {bd_reg, 15'h0000, ip_reg, 10'h000};
      ADDR_EPC:   bus.rdata = epc_reg;
      ADDR_PRID:  bus.rdata = PRID;
      default:    bus.rdata = '0;
    endcase
  end

  assign bus.int_req = int_req_w;
  assign bus.epc     = epc_reg;

endmodule

// File: tb/tb_cp0_int_ctrl.sv
// Bench for cp0_int_ctrl: reset reads, a directed vector table, an asynchronous
// reset check and randomized traffic compared against a word-level model.
module tb_cp0_int_ctrl;

`ifdef CP0_HWINT_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif
  localparam logic [31:0] PRID_VAL = 32'h0000_4D50;

  logic       clk;
  logic       rst_n;
  logic [5:0] hw_int;

  cp0_int_ctrl_if bus ();

  cp0_int_ctrl #(.PRID(PRID_VAL)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .hw_int (hw_int),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Word-level reference: registers held as architectural 32-bit words.
  logic [31:0] m_sr, m_cause, m_epc;
  logic [5:0]  m_hwq[$];

  task automatic model_reset();
    m_sr    = '0;
    m_cause = '0;
    m_epc   = '0;
    m_hwq.delete();
    for (int i = 0; i < LAT - 1; i++) m_hwq.push_back(6'd0);
  endtask

  function automatic logic m_req();
    return ((m_sr[15:10] & m_cause[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID_VAL;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step(input logic w, input logic [4:0] a, input logic [31:0] wd,
                            input logic [5:0] h, input logic [31:0] p, input logic b,
                            input logic ak, input logic er);
    logic [31:0] sr_n, epc_n;
    logic        bd_n, fire;
    logic [5:0]  ip_n;
    fire  = ak && m_req();
    sr_n  = m_sr;
    epc_n = m_epc;
    bd_n  = m_cause[31];
    if (w && a == 5'd12) sr_n = wd & 32'h0000_FC03;
    if (w && a == 5'd14) epc_n = wd & 32'hFFFF_FFFC;
    if (er && m_sr[1]) sr_n[1] = 1'b0;
    if (fire) begin
      sr_n[1] = 1'b1;
      epc_n   = b ? p - 32'd4 : p;
      bd_n    = b;
    end
    m_hwq.push_back(h);
    ip_n    = m_hwq.pop_front();
    m_sr    = sr_n;
    m_epc   = epc_n;
    m_cause = {bd_n, 15'd0, ip_n, 10'd0};
  endtask

  // One clock cycle: drive at the falling edge, let outputs settle, advance the model.
  task automatic drive(input logic w, input logic [4:0] a, input logic [31:0] wd,
                       input logic [5:0] h, input logic [31:0] p, input logic b,
                       input logic ak, input logic er, input logic use_model);
    @(negedge clk);
    bus.we      = w;
    bus.addr    = a;
    bus.wdata   = wd;
    hw_int      = h;
    bus.pc      = p;
    bus.bd      = b;
    bus.int_ack = ak;
    bus.eret    = er;
    #1;
    if (use_model) begin
      chk("rnd_int_req", {31'd0, bus.int_req}, {31'd0, m_req()});
      chk("rnd_rdata", bus.rdata, m_read(a));
      chk("rnd_epc", bus.epc, m_epc);
    end
    model_step(w, a, wd, h, p, b, ak, er);
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [5:0]  hw;
    logic [31:0] pc;
    logic        bd;
    logic        ack;
    logic        eret;
    logic        x_req;
    logic [31:0] x_rdata;
    logic [31:0] x_epc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic w, logic [4:0] a, logic [31:0] wd, logic [5:0] h,
                              logic [31:0] p, logic b, logic ak, logic er,
                              logic xr, logic [31:0] xd, logic [31:0] xe);
    vec_t v;
    v.we = w; v.addr = a; v.wdata = wd; v.hw = h; v.pc = p; v.bd = b;
    v.ack = ak; v.eret = er; v.x_req = xr; v.x_rdata = xd; v.x_epc = xe;
    return v;
  endfunction

  initial begin
    logic [5:0] prev_hw;
    n_checks = 0;
    n_fail   = 0;
    rst_n       = 1'b0;
    hw_int      = '0;
    bus.we      = 1'b0;
    bus.addr    = '0;
    bus.wdata   = '0;
    bus.pc      = '0;
    bus.bd      = 1'b0;
    bus.int_ack = 1'b0;
    bus.eret    = 1'b0;
    model_reset();

    // Expected outputs are the settled values in that row's cycle, before its edge.
    //            we addr wdata          hw      pc            bd ack er  req rdata          epc
    tbl.push_back(mk(1, 12, 32'h0000_0401, 6'd0, 32'h0,        0, 0, 0,  0, 32'h0000_0000, 32'h0));
    tbl.push_back(mk(0, 12, 32'h0,         6'd1, 32'h0,        0, 0, 0,  0, 32'h0000_0401, 32'h0));
    tbl.push_back(mk(0, 12, 32'h0,         6'd1, 32'h0,        0, 0, 0,  1, 32'h0000_0401, 32'h0));
    tbl.push_back(mk(0, 13, 32'h0,         6'd1, 32'h0000_3010, 0, 1, 0, 1, 32'h0000_0400, 32'h0));
    tbl.push_back(mk(0, 12, 32'h0,         6'd1, 32'h0,        0, 0, 0,  0, 32'h0000_0403, 32'h0000_3010));
    tbl.push_back(mk(0, 13, 32'h0,         6'd1, 32'h0,        0, 0, 0,  0, 32'h0000_0400, 32'h0000_3010));
    tbl.push_back(mk(0, 12, 32'h0,         6'd1, 32'h0,        0, 0, 1,  0, 32'h0000_0403, 32'h0000_3010));
    tbl.push_back(mk(0, 12, 32'h0,         6'd1, 32'h0,        0, 0, 0,  1, 32'h0000_0401, 32'h0000_3010));
    tbl.push_back(mk(0, 12, 32'h0,         6'd1, 32'h0,        0, 0, 1,  1, 32'h0000_0401, 32'h0000_3010));
    tbl.push_back(mk(0, 14, 32'h0,         6'd1, 32'h0,        0, 0, 0,  1, 32'h0000_3010, 32'h0000_3010));
    tbl.push_back(mk(0, 14, 32'h0,         6'd1, 32'h0000_3000, 1, 1, 0, 1, 32'h0000_3010, 32'h0000_3010));
    tbl.push_back(mk(0, 13, 32'h0,         6'd1, 32'h0,        0, 0, 0,  0, 32'h8000_0400, 32'h0000_2FFC));
    tbl.push_back(mk(0, 12, 32'h0,         6'd1, 32'h0,        0, 0, 1,  0, 32'h0000_0403, 32'h0000_2FFC));
    tbl.push_back(mk(1, 12, 32'h0000_0801, 6'd1, 32'h0,        0, 0, 0,  1, 32'h0000_0401, 32'h0000_2FFC));
    tbl.push_back(mk(0, 12, 32'h0,         6'd1, 32'h0,        0, 0, 0,  0, 32'h0000_0801, 32'h0000_2FFC));
    tbl.push_back(mk(1, 12, 32'h0000_0C01, 6'd1, 32'h0,        0, 0, 0,  0, 32'h0000_0801, 32'h0000_2FFC));
    tbl.push_back(mk(0, 12, 32'h0,         6'd1, 32'h0,        0, 0, 0,  1, 32'h0000_0C01, 32'h0000_2FFC));
    tbl.push_back(mk(1, 14, 32'h1234_5678, 6'd1, 32'h0000_4000, 0, 1, 0, 1, 32'h0000_2FFC, 32'h0000_2FFC));
    tbl.push_back(mk(0, 14, 32'h0,         6'd1, 32'h0,        0, 0, 0,  0, 32'h0000_4000, 32'h0000_4000));
    tbl.push_back(mk(0, 12, 32'h0,         6'd1, 32'h0,        0, 0, 1,  0, 32'h0000_0C03, 32'h0000_4000));
    tbl.push_back(mk(1, 12, 32'h0000_0C00, 6'd1, 32'h0,        1, 1, 0,  1, 32'h0000_0C01, 32'h0000_4000));
    tbl.push_back(mk(0, 12, 32'h0,         6'd1, 32'h0,        0, 0, 0,  0, 32'h0000_0C02, 32'hFFFF_FFFC));
    tbl.push_back(mk(0, 13, 32'h0,         6'd0, 32'h0,        0, 0, 0,  0, 32'h8000_0400, 32'hFFFF_FFFC));
    tbl.push_back(mk(0, 13, 32'h0,         6'd0, 32'h0,        0, 0, 0,  0, 32'h8000_0000, 32'hFFFF_FFFC));
    tbl.push_back(mk(1, 13, 32'h0,         6'd0, 32'h0,        0, 0, 0,  0, 32'h8000_0000, 32'hFFFF_FFFC));
    tbl.push_back(mk(0, 13, 32'h0,         6'd0, 32'h0,        0, 0, 0,  0, 32'h8000_0000, 32'hFFFF_FFFC));
    tbl.push_back(mk(1, 20, 32'hFFFF_FFFF, 6'd0, 32'h0,        0, 0, 0,  0, 32'h0000_0000, 32'hFFFF_FFFC));
    tbl.push_back(mk(0, 12, 32'h0,         6'd0, 32'h0,        0, 0, 0,  0, 32'h0000_0C02, 32'hFFFF_FFFC));

    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state: every register number reads 0 except PRId.
    for (int a = 0; a < 32; a++) begin
      drive(0, 5'(a), 32'h0, 6'd0, 32'h0, 0, 0, 0, 0);
      chk($sformatf("reset_rdata_%0d", a), bus.rdata, (a == 15) ? PRID_VAL : 32'h0);
    end
    chk("reset_int_req", {31'd0, bus.int_req}, 32'd0);
    chk("reset_epc", bus.epc, 32'd0);
    $display("reset reads done: int_req=%0b epc=%h", bus.int_req, bus.epc);

    prev_hw = 6'd0;
    for (int i = 0; i < tbl.size(); i++) begin
      // Extra synchroniser stages are absorbed by idle cycles after a hw_int change.
      if (tbl[i].hw != prev_hw)
        for (int k = 0; k < LAT - 1; k++)
          drive(0, tbl[i].addr, 32'h0, tbl[i].hw, 32'h0, 0, 0, 0, 0);
      prev_hw = tbl[i].hw;
      drive(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].hw, tbl[i].pc, tbl[i].bd,
            tbl[i].ack, tbl[i].eret, 0);
      chk($sformatf("vec%0d_int_req", i), {31'd0, bus.int_req}, {31'd0, tbl[i].x_req});
      chk($sformatf("vec%0d_rdata", i), bus.rdata, tbl[i].x_rdata);
      chk($sformatf("vec%0d_epc", i), bus.epc, tbl[i].x_epc);
      $display("vec %0d: we=%0b addr=%0d wdata=%h hw=%b ack=%0b eret=%0b -> req=%0b rdata=%h epc=%h",
               i, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].hw, tbl[i].ack, tbl[i].eret,
               bus.int_req, bus.rdata, bus.epc);
    end

    // Asynchronous reset while in the handler: clears with no clock edge.
    @(negedge clk);
    bus.we = 1'b0; bus.int_ack = 1'b0; bus.eret = 1'b0; bus.addr = 5'd12;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_sr", bus.rdata, 32'h0);
    chk("async_rst_epc", bus.epc, 32'h0);
    chk("async_rst_int_req", {31'd0, bus.int_req}, 32'd0);
    bus.addr = 5'd13;
    #1;
    chk("async_rst_cause", bus.rdata, 32'h0);
    $display("async reset: sr/epc/cause cleared, int_req=%0b", bus.int_req);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic against the reference model.
    for (int n = 0; n < 300; n++) begin
      logic        w, b, ak, er;
      logic [4:0]  a;
      logic [31:0] wd, p;
      logic [5:0]  h;
      case ($urandom_range(0, 4))
        0: a = 5'd12;
        1: a = 5'd13;
        2: a = 5'd14;
        3: a = 5'd15;
        default: a = 5'($urandom_range(0, 31));
      endcase
      w  = ($urandom_range(0, 4) == 0);
      wd = $urandom;
      if ($urandom_range(0, 3) == 0) wd[0] = 1'b1;
      h  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : hw_int;
      p  = ($urandom_range(0, 9) == 0) ? 32'h0 : ($urandom & 32'hFFFF_FFFC);
      b  = $urandom_range(0, 1) == 1;
      ak = ($urandom_range(0, 2) == 0);
      er = ($urandom_range(0, 3) == 0);
      drive(w, a, wd, h, p, b, ak, er, 1);
      $display("rnd %0d: we=%0b addr=%0d hw=%b ack=%0b eret=%0b req=%0b rdata=%h epc=%h",
               n, w, a, h, ak, er, bus.int_req, bus.rdata, bus.epc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
